// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Shared definitions for the LED fade controller: default level
//             width and the fade FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

    // Default brightness level width; duty = level / 2**LEVEL_W.
    localparam int DEF_LEVEL_W = 4;

    // Fade controller states. Width is explicit so the state register has a
    // fixed, known size in every tool.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        DOWN    = 3'd2,
        BR_UP   = 3'd3,
        BR_DOWN = 3'd4
    } fade_state_t;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_sd_core.sv
`default_nettype none
// ============================================================================
//  Module   : led_sd_core
//  Purpose  : First-order sigma-delta dimmer. The carry out of a LEVEL_W-bit
//             accumulator drives the LED, so over any 2**LEVEL_W cycles with a
//             constant level the LED is high exactly 'level' times.
//  Ports    : FPGA_CLK   in   system clock, rising edge
//             FPGA_RST_N in   synchronous active-low reset
//             level      in   LEVEL_W  applied brightness level
//             led        out  registered LED drive (accumulator carry)
//  Revision : 1.0 - initial release
// ============================================================================
module led_sd_core #(
    parameter int LEVEL_W = 4
) (
    input  logic               FPGA_CLK,
    input  logic               FPGA_RST_N,
    input  logic [LEVEL_W-1:0] level,
    output logic               led
);

    // One extra bit holds the carry of the most recent addition.
    logic [LEVEL_W:0] r_acc;

    always_ff @(posedge FPGA_CLK) begin
        if (!FPGA_RST_N) begin
            r_acc <= '0;
            led   <= 1'b0;
        end else begin
            // The previous carry is discarded; only the residue accumulates.
            r_acc <= {1'b0, r_acc[LEVEL_W-1:0]} + {1'b0, level};
            led   <= r_acc[LEVEL_W];
        end
    end

endmodule : led_sd_core
`default_nettype wire

// File: rtl/led_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_fade_ctrl
//  Purpose  : LED brightness controller. Ramps the applied level one step per
//             prescaler tick toward the switch-selected target, or runs a
//             0 -> target -> 0 breathing sweep when MODE is set. Drives the
//             sigma-delta dimmer core.
//  Ports    : FPGA_CLK   in   system clock, rising edge
//             FPGA_RST_N in   synchronous active-low reset
//             F_SW       in   LEVEL_W  target brightness (asynchronous)
//             MODE       in   0 = track target, 1 = breathe (asynchronous)
//             F_LED      out  sigma-delta LED drive
//             LEVEL      out  LEVEL_W  currently applied level
//             BUSY       out  high while the FSM is not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module led_fade_ctrl #(
    parameter int LEVEL_W   = led_pkg::DEF_LEVEL_W,
    parameter int PRESC_DIV = 500000,
    parameter int PRESC_W   = 20
) (
    input  logic               FPGA_CLK,
    input  logic               FPGA_RST_N,
    input  logic [LEVEL_W-1:0] F_SW,
    input  logic               MODE,
    output logic               F_LED,
    output logic [LEVEL_W-1:0] LEVEL,
    output logic               BUSY
);

    import led_pkg::*;

    localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(PRESC_DIV - 1);
    localparam logic [LEVEL_W-1:0] c_one        = LEVEL_W'(1);

    // Two-flop synchronizers for the asynchronous switch inputs.
    logic [LEVEL_W-1:0] r_sw_meta;
    logic [LEVEL_W-1:0] r_sw_sync;
    logic               r_mode_meta;
    logic               r_mode_sync;

    logic [PRESC_W-1:0] r_presc;
    fade_state_t        r_state;
    logic [LEVEL_W-1:0] r_level;
    logic               r_busy;

    logic               w_tick;
    logic               w_lt;
    logic               w_gt;
    logic [LEVEL_W-1:0] w_level_inc;
    logic [LEVEL_W-1:0] w_level_dec;
    fade_state_t        w_next_state;
    fade_state_t        w_settle_state;
    logic [LEVEL_W-1:0] w_next_level;

    assign w_tick      = (r_presc == c_presc_last);
    assign w_lt        = (r_level < r_sw_sync);
    assign w_gt        = (r_level > r_sw_sync);
    assign w_level_inc = r_level + c_one;
    assign w_level_dec = r_level - c_one;

    // Where to go when leaving breathing: ramp toward target, no step now.
    assign w_settle_state = w_lt ? UP : (w_gt ? DOWN : IDLE);

    // Next-state / next-level. Every increment is guarded by level < target
    // and every decrement by level > target or level != 0, so the level
    // saturates inside 0..2**LEVEL_W-1 without explicit clamping.
    always_comb begin
        w_next_state = r_state;
        w_next_level = r_level;
        case (r_state)
            IDLE: begin
                if (r_mode_sync) begin
                    w_next_state = BR_UP;
                end else if (w_lt) begin
                    w_next_state = UP;
                end else if (w_gt) begin
                    w_next_state = DOWN;
                end
            end
            UP, DOWN: begin
                // Target is re-read every tick, so a target that crossed the
                // level flips the ramp direction on this very tick.
                if (w_lt) begin
                    w_next_level = w_level_inc;
                    w_next_state = (w_level_inc == r_sw_sync) ? IDLE : UP;
                end else if (w_gt) begin
                    w_next_level = w_level_dec;
                    w_next_state = (w_level_dec == r_sw_sync) ? IDLE : DOWN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BR_UP: begin
                if (!r_mode_sync) begin
                    w_next_state = w_settle_state;
                end else if (w_lt) begin
                    w_next_level = w_level_inc;
                end else begin
                    w_next_state = BR_DOWN;
                end
            end
            BR_DOWN: begin
                if (!r_mode_sync) begin
                    w_next_state = w_settle_state;
                end else if (r_level != '0) begin
                    w_next_level = w_level_dec;
                end else begin
                    w_next_state = BR_UP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge FPGA_CLK) begin
        if (!FPGA_RST_N) begin
            r_sw_meta   <= '0;
            r_sw_sync   <= '0;
            r_mode_meta <= 1'b0;
            r_mode_sync <= 1'b0;
            r_presc     <= '0;
            r_state     <= IDLE;
            r_level     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_sw_meta   <= F_SW;
            r_sw_sync   <= r_sw_meta;
            r_mode_meta <= MODE;
            r_mode_sync <= r_mode_meta;
            r_presc     <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
                r_state <= w_next_state;
                r_level <= w_next_level;
                r_busy  <= (w_next_state != IDLE);
            end
        end
    end

    assign LEVEL = r_level;
    assign BUSY  = r_busy;

    led_sd_core #(
        .LEVEL_W (LEVEL_W)
    ) u_sd_core (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST_N (FPGA_RST_N),
        .level      (r_level),
        .led        (F_LED)
    );

endmodule : led_fade_ctrl
`default_nettype wire

// File: tb/tb_led_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_fade_ctrl
//  Purpose  : Self-checking bench for led_fade_ctrl. A behavioural model
//             tracks the expected level/busy stream; every expected change is
//             queued with its cycle number and popped by a monitor when the
//             DUT outputs change. LED duty and reset values are also checked.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_fade_ctrl;

    localparam int LW  = 4;
    localparam int DIV = 4;

    logic          FPGA_CLK   = 1'b0;
    logic          FPGA_RST_N = 1'b0;
    logic [LW-1:0] F_SW       = '0;
    logic          MODE       = 1'b0;
    logic          F_LED;
    logic [LW-1:0] LEVEL;
    logic          BUSY;

    led_fade_ctrl #(
        .LEVEL_W   (LW),
        .PRESC_DIV (DIV),
        .PRESC_W   (20)
    ) dut (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST_N (FPGA_RST_N),
        .F_SW       (F_SW),
        .MODE       (MODE),
        .F_LED      (F_LED),
        .LEVEL      (LEVEL),
        .BUSY       (BUSY)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_RISE, M_FALL, M_BR_RISE, M_BR_FALL} ph_t;
    typedef struct {
        int cyc;
        int lvl;
        int busy;
    } exp_t;

    exp_t q[$];
    ph_t  m_ph       = M_IDLE;
    int   m_lvl      = 0;
    int   m_busy     = 0;
    int   m_cnt      = 0;
    int   m_stable   = 0;
    bit   m_in_reset = 1'b1;
    int   sw_pipe[2] = '{0, 0};
    int   md_pipe[2] = '{0, 0};

    // One tick of the fade rules, in plain arithmetic.
    function automatic void fade_rule(input ph_t ph, input int lvl, input int tgt,
                                      input bit md, output ph_t nph, output int nlvl);
        int dir;
        dir  = (tgt > lvl) ? 1 : ((tgt < lvl) ? -1 : 0);
        nph  = ph;
        nlvl = lvl;
        case (ph)
            M_IDLE: begin
                if (md)           nph = M_BR_RISE;
                else if (dir > 0) nph = M_RISE;
                else if (dir < 0) nph = M_FALL;
            end
            M_RISE, M_FALL: begin
                nlvl = lvl + dir;
                if (nlvl == tgt)  nph = M_IDLE;
                else              nph = (dir > 0) ? M_RISE : M_FALL;
            end
            M_BR_RISE, M_BR_FALL: begin
                if (!md) begin
                    nph = (dir > 0) ? M_RISE : ((dir < 0) ? M_FALL : M_IDLE);
                end else if (ph == M_BR_RISE) begin
                    if (lvl < tgt) nlvl = lvl + 1;
                    else           nph  = M_BR_FALL;
                end else begin
                    if (lvl > 0)   nlvl = lvl - 1;
                    else           nph  = M_BR_RISE;
                end
            end
            default: nph = M_IDLE;
        endcase
        if (nlvl < 0)             nlvl = 0;
        if (nlvl > (1 << LW) - 1) nlvl = (1 << LW) - 1;
    endfunction

    initial begin
        int   old_l;
        int   old_b;
        ph_t  nph;
        int   nlvl;
        forever begin
            @(posedge FPGA_CLK);
            cyc   = cyc + 1;
            old_l = m_lvl;
            old_b = m_busy;
            if (!FPGA_RST_N) begin
                m_in_reset = 1'b1;
                m_ph       = M_IDLE;
                m_lvl      = 0;
                m_busy     = 0;
                m_cnt      = 0;
                m_stable   = 0;
                sw_pipe    = '{0, 0};
                md_pipe    = '{0, 0};
            end else begin
                m_in_reset = 1'b0;
                if (m_cnt == DIV - 1) begin
                    fade_rule(m_ph, m_lvl, sw_pipe[1], md_pipe[1] != 0, nph, nlvl);
                    m_ph   = nph;
                    m_lvl  = nlvl;
                    m_busy = (m_ph != M_IDLE) ? 1 : 0;
                end
                m_cnt      = (m_cnt + 1) % DIV;
                sw_pipe[1] = sw_pipe[0];
                sw_pipe[0] = int'(F_SW);
                md_pipe[1] = md_pipe[0];
                md_pipe[0] = int'(MODE);
                m_stable   = (m_lvl == old_l) ? m_stable + 1 : 0;
            end
            if (m_lvl != old_l || m_busy != old_b)
                q.push_back('{cyc, m_lvl, m_busy});
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [LW-1:0] pl;
        logic          pb;
        exp_t          e;
        int            hist[16];
        int            sum;
        pl = '0;
        pb = 1'b0;
        for (int i = 0; i < 16; i++) hist[i] = 0;
        @(posedge FPGA_CLK);
        forever begin
            @(negedge FPGA_CLK);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_change: cycle %0d expected level=%0d busy=%0d, DUT level=%0d busy=%0d",
                         e.cyc, e.lvl, e.busy, LEVEL, BUSY);
            end
            if (LEVEL !== pl || BUSY !== pb) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cycle %0d DUT level=%0d busy=%0d, required level=%0d busy=%0d",
                             cyc, LEVEL, BUSY, m_lvl, m_busy);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || LEVEL !== LW'(e.lvl) || BUSY !== e.busy[0]) begin
                        errors++;
                        $display("FAIL level_busy: cycle %0d DUT level=%0d busy=%0d, required cycle %0d level=%0d busy=%0d",
                                 cyc, LEVEL, BUSY, e.cyc, e.lvl, e.busy);
                    end
                end
                pl = LEVEL;
                pb = BUSY;
            end
            if (m_in_reset) begin
                checks++;
                if (LEVEL !== '0 || BUSY !== 1'b0 || F_LED !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: cycle %0d level=%0d busy=%0d led=%0d, required all 0",
                             cyc, LEVEL, BUSY, F_LED);
                end
            end
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = (F_LED === 1'b1) ? 1 : 0;
            if (!m_in_reset && m_stable >= 18 && (cyc % 16) == 0) begin
                sum = 0;
                for (int i = 0; i < 16; i++) sum += hist[i];
                checks++;
                if (sum != m_lvl) begin
                    errors++;
                    $display("FAIL led_duty: cycle %0d highs per 16 = %0d, required %0d", cyc, sum, m_lvl);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_level(input int lvl, input bit need_idle, input int budget, input string name);
        int n;
        n = 0;
        while (!(m_lvl == lvl && (!need_idle || m_ph == M_IDLE)) && n < budget) begin
            @(negedge FPGA_CLK);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: level=%0d after %0d cycles, required %0d", name, m_lvl, n, lvl);
        end
    endtask

    initial begin
        int tgt;
        repeat (3) @(negedge FPGA_CLK);
        FPGA_RST_N = 1'b1;
        repeat (64) @(negedge FPGA_CLK);

        F_SW = 4'd5;
        wait_level(5, 1'b1, 200, "ramp5");
        repeat (48) @(negedge FPGA_CLK);

        F_SW = 4'd2;
        wait_level(2, 1'b1, 200, "down2");
        repeat (48) @(negedge FPGA_CLK);

        F_SW = 4'd15;
        wait_level(9, 1'b0, 200, "up9");
        F_SW = 4'd3;
        wait_level(3, 1'b1, 200, "down3");
        repeat (40) @(negedge FPGA_CLK);

        F_SW = 4'd0;
        wait_level(0, 1'b1, 200, "zero");
        F_SW = 4'd3;
        MODE = 1'b1;
        repeat (120) @(negedge FPGA_CLK);
        wait_level(1, 1'b0, 200, "breath1");
        MODE = 1'b0;
        wait_level(3, 1'b1, 200, "settle3");
        repeat (40) @(negedge FPGA_CLK);

        F_SW = 4'd15;
        wait_level(7, 1'b0, 200, "up7");
        FPGA_RST_N = 1'b0;
        @(negedge FPGA_CLK);
        FPGA_RST_N = 1'b1;
        wait_level(15, 1'b1, 400, "restart15");
        repeat (40) @(negedge FPGA_CLK);

        for (int it = 0; it < 25; it++) begin
            F_SW = LW'($urandom_range(0, 15));
            MODE = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                FPGA_RST_N = 1'b0;
                @(negedge FPGA_CLK);
                FPGA_RST_N = 1'b1;
            end
            repeat ($urandom_range(8, 150)) @(negedge FPGA_CLK);
        end

        MODE = 1'b0;
        tgt  = int'($urandom_range(0, 15));
        F_SW = LW'(tgt);
        wait_level(tgt, 1'b1, 400, "final");
        repeat (40) @(negedge FPGA_CLK);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expected changes left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_led_fade_ctrl
`default_nettype wire
